// File: rtl/rotor_stepper_if.sv
// Keypress / cipher-path handshake bundle for the rotor stepper.
// The master side is the keyboard front end plus the downstream cipher path;
// the slave side is the stepper itself.
interface rotor_stepper_if #(
  parameter int CNT_W = 16
) ();

  // Position load request and the initial rotor settings that go with it
  logic             load;
  logic [4:0]       init0;
  logic [4:0]       init1;
  logic [4:0]       init2;

  // Keypress handshake
  logic             key_valid;
  logic             key_ready;

  // Rotor positions presented to the forward and reverse rotor stages
  logic [4:0]       pos0;
  logic [4:0]       pos1;
  logic [4:0]       pos2;
  logic             pos_valid;

  // Completion from the combinational cipher path
  logic             path_done;

  // Number of characters accepted since reset or the last load
  logic [CNT_W-1:0] char_count;

  modport master (
    output load,
    output init0,
    output init1,
    output init2,
    output key_valid,
    output path_done,
    input  key_ready,
    input  pos0,
    input  pos1,
    input  pos2,
    input  pos_valid,
    input  char_count
  );

  modport slave (
    input  load,
    input  init0,
    input  init1,
    input  init2,
    input  key_valid,
    input  path_done,
    output key_ready,
    output pos0,
    output pos1,
    output pos2,
    output pos_valid,
    output char_count
  );

endinterface

// File: rtl/rotor_stepper.sv
// Three-rotor stepping controller. Holds the position of each rotor, steps
// them once per accepted keypress using notch carries (including the middle
// rotor double-step), and keeps the positions stable while the downstream
// cipher path works on the character.
module rotor_stepper #(
  parameter logic [4:0] NOTCH0 = 5'd16,
  parameter logic [4:0] NOTCH1 = 5'd4,
  parameter int         CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  rotor_stepper_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [4:0]       pos0_q;
  logic [4:0]       pos1_q;
  logic [4:0]       pos2_q;
  logic [CNT_W-1:0] count_q;

  logic             do_load;
  logic             accept;
  logic             carry1;
  logic             carry2;
  logic [4:0]       step0;
  logic [4:0]       step1;
  logic [4:0]       step2;
  logic [4:0]       fold0;
  logic [4:0]       fold1;
  logic [4:0]       fold2;

  // Map a 5-bit setting into the 0..25 ring (26..31 wrap to 0..5)
  function automatic logic [4:0] fold26(input logic [4:0] v);
    if (v >= 5'd26)
      return v - 5'd26;
    else
      return v;
  endfunction

  // Advance one position around the 26-letter ring
  function automatic logic [4:0] inc26(input logic [4:0] v);
    if (v == 5'd25)
      return 5'd0;
    else
      return v + 5'd1;
  endfunction

  // Load has priority over a keypress; both only act while idle
  assign do_load = (state_q == IDLE) && bus.load;
  assign accept  = (state_q == IDLE) && !bus.load && bus.key_valid;

  // Notch carries are taken from the positions before this step, so a middle
  // rotor sitting on its notch carries into rotor 2 and also steps itself
  assign carry1 = (pos0_q == NOTCH0) || (pos1_q == NOTCH1);
  assign carry2 = (pos1_q == NOTCH1);

  assign step0 = inc26(pos0_q);
  assign step1 = carry1 ? inc26(pos1_q) : pos1_q;
  assign step2 = carry2 ? inc26(pos2_q) : pos2_q;

  assign fold0 = fold26(bus.init0);
  assign fold1 = fold26(bus.init1);
  assign fold2 = fold26(bus.init2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state: accept a key while idle, return to idle once the path is done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = VALID;
      end
      VALID: begin
        if (bus.path_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Rotor positions: load normalised settings or step on an accepted key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos0_q <= 5'd0;
      pos1_q <= 5'd0;
      pos2_q <= 5'd0;
    end else if (do_load) begin
      pos0_q <= fold0;
      pos1_q <= fold1;
      pos2_q <= fold2;
    end else if (accept) begin
      pos0_q <= step0;
      pos1_q <= step1;
      pos2_q <= step2;
    end
  end

  // Character counter: cleared by load, counts accepts, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (do_load)
      count_q <= '0;
    else if (accept && (count_q != {CNT_W{1'b1}}))
      count_q <= count_q + 1'b1;
  end

  assign bus.key_ready  = (state_q == IDLE);
  assign bus.pos_valid  = (state_q == VALID);
  assign bus.pos0       = pos0_q;
  assign bus.pos1       = pos1_q;
  assign bus.pos2       = pos2_q;
  assign bus.char_count = count_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper. A second instance with a 4-bit counter
// follows the same stimulus to exercise counter saturation.
module tb_rotor_stepper;

  logic clk;
  logic rst;

  int n_assert;
  int n_fail;

  rotor_stepper_if #(.CNT_W(16)) bus ();
  rotor_stepper_if #(.CNT_W(4))  bus4 ();

  rotor_stepper #(.NOTCH0(5'd16), .NOTCH1(5'd4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rotor_stepper #(.NOTCH0(5'd16), .NOTCH1(5'd4), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // The small-counter instance sees exactly the same inputs
  assign bus4.load      = bus.load;
  assign bus4.init0     = bus.init0;
  assign bus4.init1     = bus.init1;
  assign bus4.init2     = bus.init2;
  assign bus4.key_valid = bus.key_valid;
  assign bus4.path_done = bus.path_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [4:0] p0,
                           input logic [4:0] p1, input logic [4:0] p2);
    check_output(tag, {17'd0, bus.pos0, bus.pos1, bus.pos2}, {17'd0, p0, p1, p2});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ld, input logic kv, input logic pd,
                                input logic [4:0] i0, input logic [4:0] i1,
                                input logic [4:0] i2);
    bus.load      = ld;
    bus.key_valid = kv;
    bus.path_done = pd;
    bus.init0     = i0;
    bus.init1     = i1;
    bus.init2     = i2;
    tick();
    bus.load      = 1'b0;
    bus.key_valid = 1'b0;
    bus.path_done = 1'b0;
  endtask

  task automatic load_init(input logic [4:0] i0, input logic [4:0] i1,
                           input logic [4:0] i2);
    apply_stimulus(1'b1, 1'b0, 1'b0, i0, i1, i2);
  endtask

  task automatic press();
    apply_stimulus(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic done();
    apply_stimulus(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.load      = 1'b0;
    bus.key_valid = 1'b0;
    bus.path_done = 1'b0;
    bus.init0     = 5'd0;
    bus.init1     = 5'd0;
    bus.init2     = 5'd0;

    // 1. Asynchronous reset mid-cycle, then one character
    #3 rst = 1'b1;
    #1;
    check_pos("rst_pos", 5'd0, 5'd0, 5'd0);
    check_output("rst_key_ready", 32'(bus.key_ready), 32'd1);
    check_output("rst_pos_valid", 32'(bus.pos_valid), 32'd0);
    check_output("rst_count", 32'(bus.char_count), 32'd0);
    #8 rst = 1'b0;
    tick();
    press();
    check_pos("t1_step", 5'd1, 5'd0, 5'd0);
    check_output("t1_pos_valid", 32'(bus.pos_valid), 32'd1);
    check_output("t1_key_ready", 32'(bus.key_ready), 32'd0);
    done();
    check_output("t1_ready_back", 32'(bus.key_ready), 32'd1);
    check_output("t1_valid_drop", 32'(bus.pos_valid), 32'd0);
    check_output("t1_count", 32'(bus.char_count), 32'd1);

    // 2. Fast rotor notch carry and load normalisation
    load_init(5'd16, 5'd0, 5'd0);
    check_pos("t2_load", 5'd16, 5'd0, 5'd0);
    check_output("t2_load_count", 32'(bus.char_count), 32'd0);
    press();
    check_pos("t2_carry", 5'd17, 5'd1, 5'd0);
    done();
    load_init(5'd28, 5'd31, 5'd26);
    check_pos("t2_fold", 5'd2, 5'd5, 5'd0);

    // 3. Middle rotor double-step
    load_init(5'd15, 5'd3, 5'd0);
    press();
    check_pos("t3_key1", 5'd16, 5'd3, 5'd0);
    done();
    press();
    check_pos("t3_key2", 5'd17, 5'd4, 5'd0);
    done();
    press();
    check_pos("t3_key3", 5'd18, 5'd5, 5'd1);
    done();
    check_output("t3_count", 32'(bus.char_count), 32'd3);

    // 4. Wrap-around of each rotor
    load_init(5'd16, 5'd4, 5'd25);
    press();
    check_pos("t4_wrap2", 5'd17, 5'd5, 5'd0);
    done();
    load_init(5'd25, 5'd25, 5'd25);
    press();
    check_pos("t4_wrap0", 5'd0, 5'd25, 5'd25);

    // 5a. Key and load ignored while positions are held
    apply_stimulus(1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7);
    check_pos("t5_frozen", 5'd0, 5'd25, 5'd25);
    check_output("t5_frozen_ready", 32'(bus.key_ready), 32'd0);
    check_output("t5_frozen_valid", 32'(bus.pos_valid), 32'd1);
    check_output("t5_frozen_count", 32'(bus.char_count), 32'd1);
    done();

    // 5b. Load beats a simultaneous key in idle
    apply_stimulus(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3);
    check_pos("t5_load_wins", 5'd3, 5'd3, 5'd3);
    check_output("t5_load_count", 32'(bus.char_count), 32'd0);
    check_output("t5_load_ready", 32'(bus.key_ready), 32'd1);

    // 5c. path_done with key_valid held: return first, accept next cycle
    press();
    check_pos("t5_first", 5'd4, 5'd3, 5'd3);
    bus.key_valid = 1'b1;
    bus.path_done = 1'b1;
    tick();
    bus.path_done = 1'b0;
    check_pos("t5_no_double", 5'd4, 5'd3, 5'd3);
    check_output("t5_idle_ready", 32'(bus.key_ready), 32'd1);
    check_output("t5_idle_count", 32'(bus.char_count), 32'd1);
    tick();
    bus.key_valid = 1'b0;
    check_pos("t5_second", 5'd5, 5'd3, 5'd3);
    check_output("t5_second_count", 32'(bus.char_count), 32'd2);
    check_output("t5_second_valid", 32'(bus.pos_valid), 32'd1);
    done();

    // 6. Reset while a character is in flight
    press();
    done();
    press();
    done();
    press();
    check_pos("t6_before", 5'd8, 5'd3, 5'd3);
    check_output("t6_before_count", 32'(bus.char_count), 32'd5);
    #2 rst = 1'b1;
    #1;
    check_pos("t6_rst_pos", 5'd0, 5'd0, 5'd0);
    check_output("t6_rst_valid", 32'(bus.pos_valid), 32'd0);
    check_output("t6_rst_ready", 32'(bus.key_ready), 32'd1);
    check_output("t6_rst_count", 32'(bus.char_count), 32'd0);
    #3 rst = 1'b0;
    tick();

    // 7. Counter saturation on the 4-bit instance
    for (int i = 0; i < 15; i++) begin
      press();
      done();
    end
    check_output("t7_count4_15", 32'(bus4.char_count), 32'd15);
    press();
    done();
    press();
    done();
    check_output("t7_count4_sat", 32'(bus4.char_count), 32'd15);
    check_output("t7_count16", 32'(bus.char_count), 32'd17);
    check_pos("t7_pos", 5'd17, 5'd1, 5'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
